pcieifc_fifo_rd_stream: RTL and testbench
=========================================

# pcieifc_fifo_rd_stream

Read-side drain adapter for the PCIe interface async FIFOs (dma rq/rc, pio cq/cc) in the `rd_clk` domain. It pops the FIFO's `empty`/`rd_en`/`dout` interface, which has a fixed read latency, and presents the entries as a valid/ready stream. A small prefetch buffer sustains one beat per clock under continuous `m_ready`. It decouples downstream backpressure from the FIFO's registered read port, so `fifo_rd_en` never depends combinationally on `m_ready`.

## Interface
- `DATA_WIDTH`, 273 — entry width; must match the FIFO instance (96/273/297/266/265).
- `RD_LATENCY`, 1 — cycles from `fifo_rd_en` high to valid `fifo_dout`; legal values 1 or 2.
- `BUF_DEPTH`, `RD_LATENCY+2` — prefetch entries (derived; do not override).
- `rd_clk` in 1 — read-domain clock.
- `rrst_n` in 1 — reset; asynchronous assert, active-low.
- `fifo_empty` in 1 — FIFO empty flag.
- `fifo_rd_en` out 1 — FIFO pop strobe.
- `fifo_dout` in DATA_WIDTH — FIFO read data, valid RD_LATENCY cycles after pop.
- `m_valid` out 1 — stream beat valid.
- `m_ready` in 1 — downstream accept.
- `m_data` out DATA_WIDTH — stream beat data.
- `buf_cnt` out clog2(BUF_DEPTH+1) — current buffer occupancy.
- `stat_clr` in 1 — synchronous clear of statistics (macro only).
- `stat_beats` out 32 — accepted beats (macro only).
- `stat_stalls` out 32 — cycles with `m_valid && !m_ready` (macro only).

## Operation
- Credit: `fifo_rd_en = rrst_n && !fifo_empty && (buf_cnt + inflight < BUF_DEPTH)`.
  - `inflight` is the popcount of the RD_LATENCY-bit pop shift register.
  - Purely combinational from registers and `fifo_empty`; no `m_ready` term.
- Pop shift register shifts each cycle. Its bit[RD_LATENCY-1] is the capture strobe: write `fifo_dout` at `wr_ptr`, then `wr_ptr++`.
- Storage is a circular buffer of BUF_DEPTH registers. Pointers are clog2(BUF_DEPTH) wide and wrap from BUF_DEPTH-1 to 0 (non-power-of-2 compare).
- `m_valid = (buf_cnt != 0)`; `m_data = buf[rd_ptr]`. On `m_valid && m_ready`, `rd_ptr++`.
- `buf_cnt` update:
  - +1 on capture only.
  - −1 on accept only.
  - Unchanged when both occur in the same cycle.
- Occupancy states, derived from `buf_cnt`:
  - EMPTY (0): `m_valid` low; FIFO popped whenever it is non-empty.
  - PARTIAL (1..BUF_DEPTH-1): streaming.
  - FULL (BUF_DEPTH): no new pops; in-flight count is 0 by construction.
- A capture while FULL is illegal (simulation assertion). Credit guarantees it never occurs.
- Order preserved strictly FIFO. No entry is dropped or duplicated.
- `m_data`/`m_valid` are held stable while `m_valid && !m_ready`.

## Timing
- Reset (`rrst_n` low, async) forces:
  - `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `buf_cnt` 0;
  - pointers and shift register 0; stats 0.
- Reset mid-operation: in-flight pops and buffered entries are discarded. The FIFO is reset by the same `rrst_n`.
- First-beat latency: FIFO non-empty in cycle N → `fifo_rd_en` in N → `m_valid` in N+RD_LATENCY+1.
- Throughput: 1 beat/cycle sustained with `m_ready` high and the FIFO non-empty.
- After `m_ready` deasserts, at most BUF_DEPTH entries accumulate. Pops stop once `buf_cnt + inflight == BUF_DEPTH`.
- `m_ready` may toggle every cycle. `fifo_empty` going high mid-burst simply stops pops; buffered beats still drain.

## Configuration
- Macro `PCIEIFC_FIFO_RD_STAT_EN`.
- Defined:
  - `stat_clr`, `stat_beats`, `stat_stalls` ports exist.
  - Counters saturate at 0xFFFF_FFFF.
  - `stat_clr` zeroes both counters next cycle, with priority over increment.
- Undefined: the three ports and the counters are absent. Datapath behaviour is identical.

## Structure
- Shared package `pcieifc_pkg`:
  - `RD_LATENCY_MAX = 2`;
  - `STAT_W = 32`;
  - helper function for BUF_DEPTH and pointer width.
- One sub-module, `pcieifc_stat_cnt`: 32-bit saturating counter with sync clear and increment enable, instantiated twice under the macro.
- Top level holds the credit logic, shift register, circular buffer and pointers.

## Test plan
- Reset, then push 8 entries 0x1..0x8 into the FIFO with `m_ready`=1 → beats 0x1..0x8 on consecutive cycles. First `m_valid` RD_LATENCY+1 cycles after the first `fifo_rd_en`.
- `m_ready`=0, FIFO holds 10 entries → `buf_cnt` settles at BUF_DEPTH (3 for RD_LATENCY 1), exactly 3 pops, `m_data` held at the first entry. Release `m_ready` → all 10 beats in order, none lost.
- Random `m_ready` (50%) with random FIFO fill, 10k entries, RD_LATENCY 1 and 2 → scoreboard order match; capture-while-FULL assertion never fires.
- Assert `rrst_n` low while `buf_cnt`=2 and one pop is in flight → same cycle: `m_valid` 0, `fifo_rd_en` 0. After release, fresh entry 0xA5 emerges as the first beat.
- Single entry with `fifo_empty` toggling every cycle → each entry is delivered once; `buf_cnt` never exceeds 1 with `m_ready`=1.
- With `PCIEIFC_FIFO_RD_STAT_EN`:
  - 5 accepted beats plus 4 stall cycles → `stat_beats`=5, `stat_stalls`=4.
  - `stat_clr` pulse → both 0 next cycle.
  - Forced counter value 0xFFFF_FFFF plus an increment → stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/pcieifc_pkg.sv
// Shared definitions for the PCIe interface FIFO read-side adapters:
// latency limits, statistics width, occupancy classification and sizing helpers.
package pcieifc_pkg;

    localparam int RD_LATENCY_MAX = 2;
    localparam int STAT_W         = 32;

    // Occupancy classification of the prefetch buffer, derived from its count.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    // Prefetch depth: enough entries to cover the FIFO read latency plus the
    // registered capture stage and one beat of slack for full throughput.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    // Width of a circular-buffer pointer addressing 'depth' entries.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pcieifc_fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream bundle for pcieifc_fifo_rd_stream.
// master: the drain adapter (pops the FIFO, sources the stream).
// slave:  the environment (the FIFO read port and the stream sink).
interface pcieifc_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 273
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/pcieifc_stat_cnt.sv
// 32-bit saturating event counter with synchronous clear (clear wins over
// increment) and asynchronous active-low reset.
module pcieifc_stat_cnt
    import pcieifc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [STAT_W-1:0] cnt
);

    logic [STAT_W-1:0] cnt_reg;
    logic [STAT_W-1:0] cnt_next;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Counter register, written every cycle so it always follows cnt_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pcieifc_fifo_rd_stream.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream through a
// small circular prefetch buffer. Pops are issued on credit (buffer space minus
// reads still in flight), so fifo_rd_en never depends on m_ready.
// Optional statistics counters are enabled by defining PCIEIFC_FIFO_RD_STAT_EN.
module pcieifc_fifo_rd_stream
    import pcieifc_pkg::*;
#(
    parameter int DATA_WIDTH = 273,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = buf_depth(RD_LATENCY)
) (
    input  logic                               rd_clk,
    input  logic                               rrst_n,
    pcieifc_fifo_rd_stream_if.master           bus,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_cnt
`ifdef PCIEIFC_FIFO_RD_STAT_EN
    ,
    input  logic                               stat_clr,
    output logic [STAT_W-1:0]                  stat_beats,
    output logic [STAT_W-1:0]                  stat_stalls
`endif
);

    localparam int PTR_W = ptr_width(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [RD_LATENCY-1:0] pop_sr_reg;
    logic [DATA_WIDTH-1:0] buf_rd [BUF_DEPTH];

    logic                  pop;
    logic                  capture;
    logic                  valid;
    logic                  accept;
    logic [CNT_W:0]        inflight;
    logic [CNT_W:0]        credit_sum;
    occ_state_e            occ_state;

    // Advance a circular pointer, wrapping at BUF_DEPTH-1 (depth need not be 2^n).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check, capture strobe, stream handshake and occupancy class.
    always_comb begin
        inflight   = (CNT_W+1)'($countones(pop_sr_reg));
        credit_sum = {1'b0, cnt_reg} + inflight;
        pop        = rrst_n && !bus.fifo_empty && (credit_sum < (CNT_W+1)'(BUF_DEPTH));
        capture    = pop_sr_reg[RD_LATENCY-1];
        valid      = (cnt_reg != '0);
        accept     = valid && bus.m_ready;
        occ_state  = OCC_PARTIAL;
        if (cnt_reg == '0) begin
            occ_state = OCC_EMPTY;
        end else if (cnt_reg == CNT_W'(BUF_DEPTH)) begin
            occ_state = OCC_FULL;
        end
    end

    // Pop pipeline, pointers and occupancy count.
    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_sr_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            pop_sr_reg <= (pop_sr_reg << 1) | RD_LATENCY'(pop);
            if (capture) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (accept) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({capture, accept})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // One register per buffer slot; a slot loads fifo_dout when the capture
    // strobe lands while the write pointer addresses it.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
        logic [DATA_WIDTH-1:0] entry_reg;

        // Slot storage.
        always_ff @(posedge rd_clk or negedge rrst_n) begin
            if (!rrst_n) begin
                entry_reg <= '0;
            end else if (capture && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= bus.fifo_dout;
            end
        end

        assign buf_rd[gi] = entry_reg;
    end

    assign bus.fifo_rd_en = pop;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_rd[rd_ptr_reg];
    assign buf_cnt        = cnt_reg;

    // Credit accounting makes a capture into a full buffer impossible.
    assert property (@(posedge rd_clk) disable iff (!rrst_n)
                     !(capture && (occ_state == OCC_FULL)));

`ifdef PCIEIFC_FIFO_RD_STAT_EN
    pcieifc_stat_cnt u_stat_beats (
        .clk   (rd_clk),
        .rst_n (rrst_n),
        .clr   (stat_clr),
        .inc   (accept),
        .cnt   (stat_beats)
    );

    pcieifc_stat_cnt u_stat_stalls (
        .clk   (rd_clk),
        .rst_n (rrst_n),
        .clr   (stat_clr),
        .inc   (valid && !bus.m_ready),
        .cnt   (stat_stalls)
    );
`endif

endmodule

// File: tb/tb_pcieifc_fifo_rd_stream.sv
// Bench for pcieifc_fifo_rd_stream: two instances (RD_LATENCY 1 and 2), each fed
// by a behavioural FIFO (array + indices + latency pipe). Delivered beats are
// compared against push order. Statistics checks run when
// PCIEIFC_FIFO_RD_STAT_EN is defined.
module tb_pcieifc_fifo_rd_stream;
    import pcieifc_pkg::*;

    localparam int DW    = 32;
    localparam int MEM_N = 32768;

    logic clk     = 1'b0;
    logic rrst_n  = 1'b0;
    logic m_ready = 1'b0;
    logic e_mask  = 1'b0;
    logic [1:0] buf_cnt1;
    logic [2:0] buf_cnt2;
    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem1 [MEM_N];
    logic [DW-1:0] mem2 [MEM_N];
    int wr1 = 0, rd1 = 0, out1 = 0;
    int wr2 = 0, rd2 = 0, out2 = 0;
    logic [DW-1:0] d1a = '0;
    logic [DW-1:0] d2a = '0;
    logic [DW-1:0] d2b = '0;

`ifdef PCIEIFC_FIFO_RD_STAT_EN
    logic stat_clr = 1'b0;
    logic [31:0] stat_beats1, stat_stalls1, stat_beats2, stat_stalls2;
`endif

    always #5 clk = ~clk;

    pcieifc_fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus1 ();
    pcieifc_fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus2 ();

    assign bus1.fifo_empty = (wr1 == rd1) || e_mask;
    assign bus1.fifo_dout  = d1a;
    assign bus1.m_ready    = m_ready;
    assign bus2.fifo_empty = (wr2 == rd2);
    assign bus2.fifo_dout  = d2b;
    assign bus2.m_ready    = m_ready;

    pcieifc_fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .rd_clk      (clk),
        .rrst_n      (rrst_n),
        .bus         (bus1),
        .buf_cnt     (buf_cnt1)
`ifdef PCIEIFC_FIFO_RD_STAT_EN
        ,
        .stat_clr    (stat_clr),
        .stat_beats  (stat_beats1),
        .stat_stalls (stat_stalls1)
`endif
    );

    pcieifc_fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
        .rd_clk      (clk),
        .rrst_n      (rrst_n),
        .bus         (bus2),
        .buf_cnt     (buf_cnt2)
`ifdef PCIEIFC_FIFO_RD_STAT_EN
        ,
        .stat_clr    (stat_clr),
        .stat_beats  (stat_beats2),
        .stat_stalls (stat_stalls2)
`endif
    );

    // FIFO model 1: data appears one cycle after the pop; reset discards contents.
    always @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd1 <= wr1;
        end else if (bus1.fifo_rd_en) begin
            d1a <= mem1[rd1 % MEM_N];
            rd1 <= rd1 + 1;
        end
    end

    // FIFO model 2: data appears two cycles after the pop; reset discards contents.
    always @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd2 <= wr2;
        end else begin
            if (bus2.fifo_rd_en) begin
                d2a <= mem2[rd2 % MEM_N];
                rd2 <= rd2 + 1;
            end
            d2b <= d2a;
        end
    end

    task automatic push1(input logic [DW-1:0] v);
        mem1[wr1 % MEM_N] = v;
        wr1++;
    endtask

    task automatic push2(input logic [DW-1:0] v);
        mem2[wr2 % MEM_N] = v;
        wr2++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        push1(32'hDEAD_0001);
        #1;
        total++;
        if (bus1.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", bus1.fifo_rd_en); end
        total++;
        if (bus1.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", bus1.m_valid); end
        total++;
        if (bus1.m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", bus1.m_data); end
        total++;
        if (buf_cnt1 !== 2'd0) begin bad++; $display("FAIL reset_buf_cnt got=%0d exp=0", buf_cnt1); end
        total++;
        if (bus2.m_valid !== 1'b0 || buf_cnt2 !== 3'd0) begin
            bad++; $display("FAIL reset_dut2 valid=%b cnt=%0d exp 0/0", bus2.m_valid, buf_cnt2);
        end
        @(negedge clk);
        rrst_n = 1'b1;
        out1 = wr1;
        out2 = wr2;
        $display("reset: done");
    endtask

    task automatic test_burst;
        logic exp_valid;
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push1(DW'(i));
        #1;
        total++;
        if (bus1.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL burst_first_pop got=%b exp=1", bus1.fifo_rd_en); end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            exp_valid = (k >= 2) && (k < 10);
            total++;
            if (bus1.m_valid !== exp_valid) begin
                bad++; $display("FAIL burst_valid cyc=%0d got=%b exp=%b", k, bus1.m_valid, exp_valid);
            end
            if (bus1.m_valid && m_ready) begin
                total++;
                if (out1 >= wr1 || bus1.m_data !== mem1[out1 % MEM_N]) begin
                    bad++; $display("FAIL burst_data cyc=%0d got=%h exp=%h", k, bus1.m_data, mem1[out1 % MEM_N]);
                end
                out1++;
            end
        end
        $display("burst: 8 beats checked");
    endtask

    task automatic test_backpressure;
        int pops = 0;
        int got  = 0;
        int first;
        @(negedge clk);
        m_ready = 1'b0;
        first = wr1;
        for (int i = 0; i < 10; i++) push1(32'h100 + DW'(i));
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus1.fifo_rd_en) pops++;
        end
        total++;
        if (pops != 3) begin bad++; $display("FAIL bp_pops got=%0d exp=3", pops); end
        total++;
        if (buf_cnt1 !== 2'd3) begin bad++; $display("FAIL bp_buf_cnt got=%0d exp=3", buf_cnt1); end
        total++;
        if (bus1.m_valid !== 1'b1 || bus1.m_data !== mem1[first % MEM_N]) begin
            bad++; $display("FAIL bp_hold valid=%b got=%h exp=%h", bus1.m_valid, bus1.m_data, mem1[first % MEM_N]);
        end
        for (int c = 0; c < 40 && got < 10; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            if (bus1.m_valid && m_ready) begin
                total++;
                if (out1 >= wr1 || bus1.m_data !== mem1[out1 % MEM_N]) begin
                    bad++; $display("FAIL bp_data got=%h exp=%h", bus1.m_data, mem1[out1 % MEM_N]);
                end
                out1++;
                got++;
            end
        end
        total++;
        if (got != 10) begin bad++; $display("FAIL bp_count got=%0d exp=10", got); end
        $display("backpressure: pops=%0d beats=%0d", pops, got);
    endtask

    task automatic test_empty_toggle;
        int got = 0;
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push1(32'h300 + DW'(i));
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (c > 0) @(negedge clk);
            e_mask = ~e_mask;
            #1;
            total++;
            if (buf_cnt1 > 2'd1) begin bad++; $display("FAIL toggle_buf_cnt got=%0d exp<=1", buf_cnt1); end
            total++;
            if (bus1.fifo_rd_en && bus1.fifo_empty) begin bad++; $display("FAIL toggle_pop_empty got=1 exp=0"); end
            if (bus1.m_valid && m_ready) begin
                total++;
                if (out1 >= wr1 || bus1.m_data !== mem1[out1 % MEM_N]) begin
                    bad++; $display("FAIL toggle_data got=%h exp=%h", bus1.m_data, mem1[out1 % MEM_N]);
                end
                out1++;
                got++;
            end
        end
        e_mask = 1'b0;
        total++;
        if (got != 6) begin bad++; $display("FAIL toggle_count got=%0d exp=6", got); end
        $display("empty_toggle: beats=%0d", got);
    endtask

    task automatic test_reset_mid;
        int  got = 0;
        logic hit = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(32'h200 + DW'(i));
        for (int c = 0; c < 10 && !hit; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (buf_cnt1 == 2'd2) hit = 1'b1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rstmid_setup got=%0d exp=2", buf_cnt1); end
        #2;
        rrst_n = 1'b0;
        #1;
        total++;
        if (bus1.m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", bus1.m_valid); end
        total++;
        if (bus1.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en got=%b exp=0", bus1.fifo_rd_en); end
        total++;
        if (buf_cnt1 !== 2'd0 || bus1.m_data !== 32'h0) begin
            bad++; $display("FAIL rstmid_state cnt=%0d data=%h exp 0/0", buf_cnt1, bus1.m_data);
        end
        @(negedge clk);
        rrst_n = 1'b1;
        out1 = wr1;
        out2 = wr2;
        @(negedge clk);
        push1(32'hA5);
        m_ready = 1'b1;
        for (int c = 0; c < 10 && got == 0; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus1.m_valid && m_ready) begin
                total++;
                if (bus1.m_data !== 32'hA5) begin bad++; $display("FAIL rstmid_first got=%h exp=a5", bus1.m_data); end
                out1++;
                got++;
            end
        end
        total++;
        if (got != 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", got); end
        $display("reset_mid: first beat after reset checked");
    endtask

`ifdef PCIEIFC_FIFO_RD_STAT_EN
    task automatic test_stats;
        int acc = 0;
        int st  = 0;
        @(negedge clk);
        m_ready  = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        total++;
        if (stat_beats1 !== 32'h0 || stat_stalls1 !== 32'h0) begin
            bad++; $display("FAIL stat_clr beats=%0d stalls=%0d exp 0/0", stat_beats1, stat_stalls1);
        end
        for (int i = 0; i < 5; i++) push1(32'h400 + DW'(i));
        for (int c = 0; c < 60 && acc < 5; c++) begin
            @(negedge clk);
            m_ready = (st >= 4);
            #1;
            if (bus1.m_valid && !m_ready) st++;
            if (bus1.m_valid && m_ready) begin
                total++;
                if (bus1.m_data !== mem1[out1 % MEM_N]) begin
                    bad++; $display("FAIL stat_data got=%h exp=%h", bus1.m_data, mem1[out1 % MEM_N]);
                end
                out1++;
                acc++;
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (stat_beats1 !== 32'd5) begin bad++; $display("FAIL stat_beats got=%0d exp=5", stat_beats1); end
        total++;
        if (stat_stalls1 !== 32'd4) begin bad++; $display("FAIL stat_stalls got=%0d exp=4", stat_stalls1); end
        force u_dut1.u_stat_beats.cnt_reg = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_dut1.u_stat_beats.cnt_reg;
        push1(32'h4FF);
        m_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 10 && acc == 0; c++) begin
            @(negedge clk);
            #1;
            if (bus1.m_valid && m_ready) begin out1++; acc++; end
        end
        @(negedge clk);
        #1;
        total++;
        if (acc != 1 || stat_beats1 !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL stat_sat got=%h exp=ffffffff beats=%0d", stat_beats1, acc);
        end
        $display("stats: beats/stalls/clear/saturation checked");
    endtask
`endif

    task automatic test_random(input int n);
        int pushed = 0;
        int start1 = out1;
        int start2 = out2;
        logic [DW-1:0] v;
        e_mask = 1'b0;
        for (int c = 0; c < 6 * n && (out1 - start1 < n || out2 - start2 < n); c++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < n && $urandom_range(0, 99) < 45) begin
                v = $urandom;
                push1(v);
                push2(v);
                pushed++;
            end
            #1;
            total++;
            if ((bus1.fifo_rd_en && bus1.fifo_empty) || (bus2.fifo_rd_en && bus2.fifo_empty)) begin
                bad++; $display("FAIL rand_pop_empty rd1=%b rd2=%b exp no pop", bus1.fifo_rd_en, bus2.fifo_rd_en);
            end
            if (bus1.m_valid && m_ready) begin
                total++;
                if (out1 >= wr1 || bus1.m_data !== mem1[out1 % MEM_N]) begin
                    bad++; $display("FAIL rand_data_l1 idx=%0d got=%h exp=%h", out1, bus1.m_data, mem1[out1 % MEM_N]);
                end
                out1++;
            end
            if (bus2.m_valid && m_ready) begin
                total++;
                if (out2 >= wr2 || bus2.m_data !== mem2[out2 % MEM_N]) begin
                    bad++; $display("FAIL rand_data_l2 idx=%0d got=%h exp=%h", out2, bus2.m_data, mem2[out2 % MEM_N]);
                end
                out2++;
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (out1 - start1 != n || buf_cnt1 !== 2'd0) begin
            bad++; $display("FAIL rand_count_l1 got=%0d exp=%0d cnt=%0d", out1 - start1, n, buf_cnt1);
        end
        total++;
        if (out2 - start2 != n || buf_cnt2 !== 3'd0) begin
            bad++; $display("FAIL rand_count_l2 got=%0d exp=%0d cnt=%0d", out2 - start2, n, buf_cnt2);
        end
        $display("random: %0d entries per instance", n);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_empty_toggle();
        test_reset_mid();
`ifdef PCIEIFC_FIFO_RD_STAT_EN
        test_stats();
`endif
        test_random(10000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
